beam_threshold_loader: RTL and testbench

Sequencer that owns the per-beam trigger thresholds of `beamform_trigger`. It holds a shadow table of NBEAMS 18-bit thresholds written from the control side and tracks which entries are dirty. On a commit request it streams the dirty entries into the trigger through `thresh_o`/`thresh_ce_o`, pulses `update_o`, waits for the trigger pipeline to settle, then reports completion. It sits between the register/control interface and `beamform_trigger`.

---
 rtl/beam_threshold_loader_if.sv | 38 +++
 rtl/beam_threshold_loader.sv | 136 +++++++++++++
 tb/tb_beam_threshold_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/beam_threshold_loader_if.sv
// beam_threshold_loader_if
//   Control-side and trigger-side bundle for beam_threshold_loader.
//   slave  : the loader (consumes writes/requests, drives threshold stream)
//   master : the controller / environment
//   Signals:
//     wr_en_i/wr_addr_i/wr_data_i  shadow-table write
//     rd_addr_i/rd_data_o          registered readback
//     load_req_i/busy_o/done_o     commit handshake
//     dirty_o                      per-beam uncommitted flags
//     thresh_o/thresh_ce_o/update_o  stream into beamform_trigger
interface beam_threshold_loader_if #(
  parameter int NBEAMS = 8
);
  localparam int AW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

  logic              wr_en_i;
  logic [AW-1:0]     wr_addr_i;
  logic [17:0]       wr_data_i;
  logic [AW-1:0]     rd_addr_i;
  logic [17:0]       rd_data_o;
  logic              load_req_i;
  logic              busy_o;
  logic              done_o;
  logic [NBEAMS-1:0] dirty_o;
  logic [17:0]       thresh_o;
  logic [NBEAMS-1:0] thresh_ce_o;
  logic              update_o;

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, load_req_i,
    output rd_data_o, busy_o, done_o, dirty_o, thresh_o, thresh_ce_o, update_o
  );

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, load_req_i,
    input  rd_data_o, busy_o, done_o, dirty_o, thresh_o, thresh_ce_o, update_o
  );
endinterface

// File: rtl/beam_threshold_loader.sv
// beam_threshold_loader
//   Holds a shadow table of NBEAMS 18-bit trigger thresholds with per-beam
//   dirty flags. A commit streams every dirty entry to beamform_trigger
//   (one beam slot per cycle, fixed latency), pulses update, waits
//   SETTLE_CYCLES and then pulses done. Reset preloads THRESH_DEFAULT,
//   marks all beams dirty and leaves a commit pending, so the trigger is
//   fully reloaded after every reset.
//   Ports:
//     clk_i  clock
//     rst_i  asynchronous active-high reset
//     bus    beam_threshold_loader_if.slave (control + trigger stream)
module beam_threshold_loader #(
  parameter int          NBEAMS         = 8,
  parameter logic [17:0] THRESH_DEFAULT = 18'd9000,
  parameter int          SETTLE_CYCLES  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  beam_threshold_loader_if.slave  bus
);
  localparam int AW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_UPDATE, S_SETTLE, S_DONE} state_t;

  state_t            r_state;
  logic [17:0]       r_table [NBEAMS];
  logic [NBEAMS-1:0] r_dirty;
  logic              r_pend;
  logic [AW-1:0]     r_idx;
  logic [7:0]        r_cnt;
  logic [17:0]       r_thresh;
  logic [17:0]       r_rd_data;
  logic [NBEAMS-1:0] r_ce;
  logic              r_update;
  logic              r_done;
  logic              r_busy;

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_req;
  logic              w_scan_hit;
  logic [NBEAMS-1:0] w_idx_hot;
  logic [NBEAMS-1:0] w_wr_hot;
  logic [NBEAMS-1:0] w_clr;

  assign w_wr_ok    = bus.wr_en_i && (32'(bus.wr_addr_i) < NBEAMS);
  assign w_rd_ok    = 32'(bus.rd_addr_i) < NBEAMS;
  assign w_req      = bus.load_req_i || r_pend;
  assign w_idx_hot  = NBEAMS'(1) << r_idx;
  assign w_wr_hot   = w_wr_ok ? (NBEAMS'(1) << bus.wr_addr_i) : '0;
  assign w_scan_hit = (r_state == S_SCAN) && r_dirty[r_idx];
  assign w_clr      = w_scan_hit ? w_idx_hot : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NBEAMS; i++) r_table[i] <= THRESH_DEFAULT;
      r_dirty   <= '1;
      r_pend    <= 1'b1;
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_thresh  <= '0;
      r_rd_data <= '0;
      r_ce      <= '0;
      r_update  <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      // Set after clear: a write landing on the beam being scanned keeps it
      // dirty, while the scan itself still ships the pre-write table value.
      r_dirty <= (r_dirty & ~w_clr) | w_wr_hot;
      if (w_wr_ok) r_table[bus.wr_addr_i] <= bus.wr_data_i;

      if (w_wr_ok && bus.wr_addr_i == bus.rd_addr_i) r_rd_data <= bus.wr_data_i;
      else if (w_rd_ok)                             r_rd_data <= r_table[bus.rd_addr_i];
      else                                          r_rd_data <= '0;

      r_ce     <= '0;
      r_update <= 1'b0;
      r_done   <= 1'b0;
      // Requests outside IDLE collapse into one pending flag.
      r_pend   <= r_pend | bus.load_req_i;

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_pend <= 1'b0;
            r_idx  <= '0;
            if (|r_dirty) begin
              r_state <= S_SCAN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_SCAN: begin
          // Every index gets a slot so latency does not depend on dirty count.
          if (r_dirty[r_idx]) begin
            r_thresh <= r_table[r_idx];
            r_ce     <= w_idx_hot;
          end
          if (r_idx == AW'(NBEAMS - 1)) r_state <= S_UPDATE;
          else                          r_idx   <= r_idx + 1'b1;
        end
        S_UPDATE: begin
          r_update <= 1'b1;
          if (SETTLE_CYCLES == 0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= 8'(SETTLE_CYCLES - 1);
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 8'd0) r_state <= S_DONE;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_data_o   = r_rd_data;
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.dirty_o     = r_dirty;
  assign bus.thresh_o    = r_thresh;
  assign bus.thresh_ce_o = r_ce;
  assign bus.update_o    = r_update;
endmodule

// File: tb/tb_beam_threshold_loader.sv
module tb_beam_threshold_loader;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  beam_threshold_loader_if #(.NBEAMS(NB)) bus ();

  beam_threshold_loader #(
    .NBEAMS(NB), .THRESH_DEFAULT(18'd9000), .SETTLE_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = thresh_ce slot, 1 = update, 2 = done
  typedef struct packed {
    logic [31:0] c;
    logic [1:0]  kind;
    logic [7:0]  ce;
    logic [17:0] th;
  } ev_t;
  ev_t q[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h) cyc=%0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push(int c, int kind, logic [7:0] ce, logic [17:0] th);
    ev_t e;
    e.c = c; e.kind = kind[1:0]; e.ce = ce; e.th = th;
    q.push_back(e);
  endtask

  task automatic exp_ce(int c, int beam, logic [17:0] th);
    logic [7:0] one;
    one = 8'd1;
    push(c, 0, one << beam, th);
  endtask

  task automatic exp_tail(int t);
    push(t + 9, 1, 8'd0, 18'd0);
    push(t + 14, 2, 8'd0, 18'd0);
  endtask

  task automatic exp_full(int t, logic [17:0] v);
    for (int i = 0; i < NB; i++) exp_ce(t + 1 + i, i, v);
    exp_tail(t);
  endtask

  // Monitor: pops one expectation per observed output event.
  task automatic mon_ev(int kind, logic [7:0] ce, logic [17:0] th);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d ce=%h th=%0d cyc=%0d", kind, ce, th, cyc);
    end else begin
      e = q.pop_front();
      if (e.c != 32'(cyc) || e.kind != kind[1:0] ||
          (kind == 0 && (e.ce != ce || e.th != th))) begin
        errors++;
        $display("FAIL event got kind=%0d ce=%h th=%0d cyc=%0d expected kind=%0d ce=%h th=%0d cyc=%0d",
                 kind, ce, th, cyc, e.kind, e.ce, e.th, e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.thresh_ce_o != '0) begin
        checks++;
        if (!$onehot(bus.thresh_ce_o) || bus.update_o) begin
          errors++;
          $display("FAIL ce_shape ce=%h update=%b cyc=%0d expected one-hot ce without update",
                   bus.thresh_ce_o, bus.update_o, cyc);
        end
        mon_ev(0, bus.thresh_ce_o, bus.thresh_o);
      end
      if (bus.update_o) mon_ev(1, 8'd0, 18'd0);
      if (bus.done_o)   mon_ev(2, 8'd0, 18'd0);
    end
  end

  task automatic wr(int a, int d);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = 3'(a);
    bus.wr_data_i = 18'(d);
    @(negedge clk);
    bus.wr_en_i   = 1'b0;
  endtask

  task automatic req(output int t);
    bus.load_req_i = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    bus.load_req_i = 1'b0;
  endtask

  task automatic wait_cyc(int e);
    int n;
    n = 0;
    while (cyc != e && n < 200) begin @(negedge clk); n++; end
    if (cyc != e) begin
      checks++; errors++;
      $display("FAIL wait_cyc got=%0d expected=%0d", cyc, e);
    end
  endtask

  task automatic wait_done(string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done_o && n < 40);
    if (!bus.done_o) begin
      checks++; errors++;
      $display("FAIL %s_timeout got=no_done expected=done within 40 cycles", nm);
    end
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_busy"},   32'(bus.busy_o), 32'd1);
    chk({nm, "_dirty"},  32'(bus.dirty_o), 32'hff);
    chk({nm, "_thresh"}, 32'(bus.thresh_o), 32'd0);
    chk({nm, "_ce"},     32'(bus.thresh_ce_o), 32'd0);
    chk({nm, "_update"}, 32'(bus.update_o), 32'd0);
    chk({nm, "_done"},   32'(bus.done_o), 32'd0);
    chk({nm, "_rd"},     32'(bus.rd_data_o), 32'd0);
  endtask

  initial begin
    int t;
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.rd_addr_i = '0; bus.load_req_i = 1'b0;

    // 1: reset values, then automatic full reload
    @(negedge clk); @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    t = cyc + 1;
    exp_full(t, 18'd9000);
    wait_done("reload");
    chk("reload_dirty", 32'(bus.dirty_o), 32'd0);
    chk("reload_busy",  32'(bus.busy_o), 32'd0);
    chk("rd_beam0",     32'(bus.rd_data_o), 32'd9000);

    // 2: beams 3 and 6
    wr(3, 12000);
    wr(6, 500);
    chk("dirty_3_6", 32'(bus.dirty_o), 32'h48);
    bus.rd_addr_i = 3'd3;
    req(t);
    exp_ce(t + 4, 3, 18'd12000);
    exp_ce(t + 7, 6, 18'd500);
    exp_tail(t);
    chk("rd_beam3", 32'(bus.rd_data_o), 32'd12000);
    chk("busy_scan", 32'(bus.busy_o), 32'd1);
    wait_done("commit36");
    chk("commit36_dirty", 32'(bus.dirty_o), 32'd0);

    // 3: nothing dirty -> done next cycle only
    req(t);
    push(t + 1, 2, 8'd0, 18'd0);
    chk("clean_busy0", 32'(bus.busy_o), 32'd0);
    wait_done("clean");
    chk("clean_cyc",   32'(cyc), 32'(t + 1));
    chk("clean_busy1", 32'(bus.busy_o), 32'd0);
    @(negedge clk); @(negedge clk);

    // 4: writes during scan, collapsed follow-up request
    wr(5, 777);
    req(t);
    exp_ce(t + 6, 5, 18'd777);
    exp_ce(t + 8, 7, 18'd2222);
    exp_tail(t);
    exp_ce(t + 15 + 3, 2, 18'd1111);
    exp_tail(t + 15);
    wait_cyc(t + 4);
    wr(2, 1111);
    bus.load_req_i = 1'b1;
    wr(7, 2222);
    bus.load_req_i = 1'b0;
    wait_done("scanwr1");
    chk("scanwr_dirty", 32'(bus.dirty_o), 32'h04);
    wait_done("scanwr2");
    chk("scanwr2_cyc",   32'(cyc), 32'(t + 29));
    chk("scanwr2_dirty", 32'(bus.dirty_o), 32'd0);

    // 5: same-cycle write to the beam being scanned
    wr(4, 300);
    bus.rd_addr_i = 3'd4;
    req(t);
    exp_ce(t + 5, 4, 18'd300);
    exp_tail(t);
    wait_cyc(t + 4);
    chk("rd_before", 32'(bus.rd_data_o), 32'd300);
    wr(4, 4444);
    chk("rd_writefirst", 32'(bus.rd_data_o), 32'd4444);
    wait_done("samecyc");
    chk("samecyc_dirty", 32'(bus.dirty_o), 32'h10);
    req(t);
    exp_ce(t + 5, 4, 18'd4444);
    exp_tail(t);
    wait_done("samecyc2");
    chk("samecyc2_dirty", 32'(bus.dirty_o), 32'd0);

    // 6: reset during SETTLE
    wr(1, 50);
    req(t);
    exp_ce(t + 2, 1, 18'd50);
    push(t + 9, 1, 8'd0, 18'd0);
    wait_cyc(t + 11);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    t = cyc + 1;
    exp_full(t, 18'd9000);
    wait_done("rstreload");
    chk("rstreload_dirty", 32'(bus.dirty_o), 32'd0);
    chk("rstreload_busy",  32'(bus.busy_o), 32'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
